hash_xor_serializer: RTL



---
 rtl/hash_xor_serializer_pkg.sv | 14 +
 rtl/hash_xor_serializer_if.sv | 27 ++
 rtl/hash_xor_shift_register.sv | 37 +++
 rtl/hash_xor_serializer.sv | 72 +++++++
 4 files changed

// File: rtl/hash_xor_serializer_pkg.sv
// Shared definitions for the hash XOR serializer: FSM encoding and default sizes.
package hash_xor_serializer_pkg;

  localparam int DEFAULT_HASH_WIDTH = 1024;
  localparam int DEFAULT_IDX_WIDTH  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/hash_xor_serializer_if.sv
// Hash intake handshake plus the bit-serial stream toward the bits-off counter.
interface hash_xor_serializer_if
  import hash_xor_serializer_pkg::*;
#(
  parameter int HASH_WIDTH = DEFAULT_HASH_WIDTH
);
  // Handshake: a hash transfers on a rising edge where hash_valid_i and
  // hash_ready_o are both 1; the producer holds valid and data stable until then.
  logic                  hash_valid_i;
  logic [HASH_WIDTH-1:0] hash_i;
  logic [HASH_WIDTH-1:0] target_i;
  logic                  hash_ready_o;
  logic                  count_reset_o;
  logic                  add_o;
  logic                  hash_xor_bit_o;
  logic                  done_o;

  modport master (
    output hash_valid_i, hash_i, target_i,
    input  hash_ready_o, count_reset_o, add_o, hash_xor_bit_o, done_o
  );

  modport slave (
    input  hash_valid_i, hash_i, target_i,
    output hash_ready_o, count_reset_o, add_o, hash_xor_bit_o, done_o
  );
endinterface

// File: rtl/hash_xor_shift_register.sv
// Holds the XOR difference and presents it one bit per shift, LSB first.
module hash_xor_shift_register
  import hash_xor_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_HASH_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit0_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit0_o = shreg_q[0];

endmodule

// File: rtl/hash_xor_serializer.sv
// Accepts a candidate/target hash pair and streams their XOR difference bit-serially,
// framed by a counter clear before the stream and a done pulse after it.
module hash_xor_serializer
  import hash_xor_serializer_pkg::*;
#(
  parameter int HASH_WIDTH = DEFAULT_HASH_WIDTH,
  parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  hash_xor_serializer_if.slave  bus,
  output state_e                state_o
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(HASH_WIDTH - 1);

  state_e               state_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic                 load;
  logic                 shift;
  logic                 shbit;

  assign load  = (state_q == ST_IDLE) && bus.hash_valid_i;
  assign shift = (state_q == ST_SHIFT);

  hash_xor_shift_register #(
    .WIDTH (HASH_WIDTH)
  ) u_shreg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.hash_i ^ bus.target_i),
    .bit0_o  (shbit)
  );

  // The index saturates on the last bit instead of wrapping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.hash_valid_i) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
          end
        end
        ST_CLEAR: state_q <= ST_SHIFT;
        ST_SHIFT: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_WIDTH'(1);
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready is masked by reset so nothing upstream sees an accept window during reset.
  assign bus.hash_ready_o   = (state_q == ST_IDLE) && !reset_i;
  assign bus.count_reset_o  = (state_q == ST_CLEAR);
  assign bus.add_o          = shift;
  assign bus.hash_xor_bit_o = shift && shbit;
  assign bus.done_o         = (state_q == ST_DONE);
  assign state_o            = state_q;

endmodule
